// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Purpose  : Turns collision hit/miss pulses into score, combo and combo-enable
//            words for the display, accepting one correct hit per beat window.
// Options  : define SCORE_KEEPER_BEST_COMBO_EN to keep a best_combo register.
// Revision : 1.0  initial release
// ============================================================================
module score_keeper #(
  parameter int unsigned SCORE_MAX          = 9999,
  parameter int unsigned HIT_POINTS         = 1,
  parameter int unsigned BONUS_POINTS       = 2,
  parameter int unsigned COMBO_BONUS_THRESH = 10,
  parameter int unsigned COMBO_SHOW_MIN     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        clear,
  input  logic        beat_tick,
  input  logic        correct_hit,
  input  logic        incorrect_hit,
  output logic [13:0] score,
  output logic [13:0] combo_count,
  output logic        combo_en,
  output logic [13:0] best_combo
);

  localparam int W = 14;

  localparam logic [W:0]   C_MAX_WIDE = (W+1)'(SCORE_MAX);
  localparam logic [W-1:0] C_MAX      = W'(SCORE_MAX);
  localparam logic [W:0]   C_HIT      = (W+1)'(HIT_POINTS);
  localparam logic [W:0]   C_BONUS    = (W+1)'(BONUS_POINTS);
  localparam logic [W-1:0] C_THRESH   = W'(COMBO_BONUS_THRESH);
  localparam logic [W-1:0] C_SHOW     = W'(COMBO_SHOW_MIN);

  typedef enum logic [1:0] {
    WAIT_BEAT = 2'd0,
    ARMED     = 2'd1,
    HIT_TAKEN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   score_q, score_d;
  logic [W-1:0]   combo_q, combo_d;
  logic           combo_en_q;

  logic           beat_s1_q, beat_s2_q, beat_hist_q;
  logic           ch_q, ih_q;

  logic           beat_edge, ch_edge, ih_edge;
  logic [W:0]     combo_inc, score_sum, points;
  logic [W-1:0]   combo_sat, score_sat;

  // Edge-detect history flops run regardless of pause so that releasing
  // pause with an input already high never looks like a fresh rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_s1_q   <= 1'b0;
      beat_s2_q   <= 1'b0;
      beat_hist_q <= 1'b0;
      ch_q        <= 1'b0;
      ih_q        <= 1'b0;
    end else begin
      beat_s1_q   <= beat_tick;
      beat_s2_q   <= beat_s1_q;
      beat_hist_q <= beat_s2_q;
      ch_q        <= correct_hit;
      ih_q        <= incorrect_hit;
    end
  end

  assign beat_edge = beat_s2_q & ~beat_hist_q;
  assign ch_edge   = correct_hit & ~ch_q;
  assign ih_edge   = incorrect_hit & ~ih_q;

  // Saturating arithmetic: one bit of headroom, then clamp.
  always_comb begin
    combo_inc = {1'b0, combo_q} + (W+1)'(1);
    combo_sat = (combo_inc > C_MAX_WIDE) ? C_MAX : combo_inc[W-1:0];
    points    = C_HIT + ((combo_sat >= C_THRESH) ? C_BONUS : '0);
    score_sum = {1'b0, score_q} + points;
    score_sat = (score_sum > C_MAX_WIDE) ? C_MAX : score_sum[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    combo_d = combo_q;
    if (clear) begin
      state_d = WAIT_BEAT;
      score_d = '0;
      combo_d = '0;
    end else if (!pause) begin
      case (state_q)
        WAIT_BEAT: begin
          if (beat_edge) state_d = ARMED;
        end
        ARMED: begin
          // A hit landing on the closing beat still belongs to this window.
          if (ih_edge) begin
            combo_d = '0;
            state_d = beat_edge ? ARMED : HIT_TAKEN;
          end else if (ch_edge) begin
            combo_d = combo_sat;
            score_d = score_sat;
            state_d = beat_edge ? ARMED : HIT_TAKEN;
          end else if (beat_edge) begin
            combo_d = '0;
          end
        end
        HIT_TAKEN: begin
          if (ih_edge)   combo_d = '0;
          if (beat_edge) state_d = ARMED;
        end
        default: state_d = WAIT_BEAT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= WAIT_BEAT;
      score_q    <= '0;
      combo_q    <= '0;
      combo_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      combo_en_q <= (combo_q >= C_SHOW);
    end
  end

  assign score       = score_q;
  assign combo_count = combo_q;
  assign combo_en    = combo_en_q;

`ifdef SCORE_KEEPER_BEST_COMBO_EN
  logic [W-1:0] best_q;

  // Survives clear so the peak from the previous game stays visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      best_q <= '0;
    end else if (combo_d > best_q) begin
      best_q <= combo_d;
    end
  end

  assign best_combo = best_q;
`else
  assign best_combo = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_keeper
// Purpose  : Scoreboard bench for score_keeper; expectations come from a small
//            behavioural model of score and combo.
// Revision : 1.0  initial release
// ============================================================================
module tb_score_keeper;

  localparam int MAX    = 9999;
  localparam int THRESH = 10;

  logic        clk = 1'b0;
  logic        reset, pause, clear, beat_tick, correct_hit, incorrect_hit;
  logic [13:0] score, combo_count, best_combo;
  logic        combo_en;

  typedef struct packed {
    logic [13:0] s;
    logic [13:0] c;
  } exp_t;

  exp_t sb[$];
  int   m_score, m_combo;
  int   checks = 0;
  int   passes = 0;

  score_keeper dut (
    .clk           (clk),
    .reset         (reset),
    .pause         (pause),
    .clear         (clear),
    .beat_tick     (beat_tick),
    .correct_hit   (correct_hit),
    .incorrect_hit (incorrect_hit),
    .score         (score),
    .combo_count   (combo_count),
    .combo_en      (combo_en),
    .best_combo    (best_combo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_hit();
    int pts;
    m_combo = (m_combo + 1 > MAX) ? MAX : m_combo + 1;
    pts     = 1 + ((m_combo >= THRESH) ? 2 : 0);
    m_score = (m_score + pts > MAX) ? MAX : m_score + pts;
  endtask

  task automatic push_exp();
    exp_t e;
    e.s = 14'(m_score);
    e.c = 14'(m_combo);
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string name, input bit en);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if (en) begin
      checks++;
      if (score !== e.s || combo_count !== e.c)
        $display("FAIL %s: score=%0d combo=%0d, expected score=%0d combo=%0d",
                 name, score, combo_count, e.s, e.c);
      else
        passes++;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    m_score = 0;
    m_combo = 0;
    push_exp();
    tick();
    clear = 1'b0;
    pop_cmp("clear", 1'b1);
  endtask

  // One beat window with a single correct hit just after it arms.
  task automatic window(input bit chk);
    beat_tick = 1'b1;
    tick();
    tick();
    beat_tick = 1'b0;
    tick();
    correct_hit = 1'b1;
    model_hit();
    push_exp();
    tick();
    pop_cmp("window", chk);
    correct_hit = 1'b0;
    tick();
  endtask

  task automatic beat_only();
    beat_tick = 1'b1;
    tick();
    tick();
    beat_tick = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; pause = 1'b0; clear = 1'b0;
    beat_tick = 1'b0; correct_hit = 1'b0; incorrect_hit = 1'b0;
    m_score = 0; m_combo = 0;
    repeat (3) tick();
    checks++;
    if (score !== 14'd0) $display("FAIL reset_score: got %0d want 0", score); else passes++;
    checks++;
    if (combo_count !== 14'd0) $display("FAIL reset_combo: got %0d want 0", combo_count); else passes++;
    checks++;
    if (combo_en !== 1'b0) $display("FAIL reset_combo_en: got %0b want 0", combo_en); else passes++;
    checks++;
    if (best_combo !== 14'd0) $display("FAIL reset_best: got %0d want 0", best_combo); else passes++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_three_windows();
    do_clear();
    repeat (3) window(1'b1);
    checks++;
    if (score !== 14'd3 || combo_count !== 14'd3)
      $display("FAIL three_windows: score=%0d combo=%0d want 3/3", score, combo_count);
    else passes++;
    checks++;
    if (combo_en !== 1'b1) $display("FAIL three_combo_en: got %0b want 1", combo_en); else passes++;
  endtask

  task automatic test_anti_mash();
    do_clear();
    window(1'b1);
    repeat (3) begin
      correct_hit = 1'b1;
      push_exp();
      tick();
      pop_cmp("anti_mash", 1'b1);
      correct_hit = 1'b0;
      tick();
    end
    checks++;
    if (score !== 14'd1 || combo_count !== 14'd1)
      $display("FAIL anti_mash_final: score=%0d combo=%0d want 1/1", score, combo_count);
    else passes++;
  endtask

  task automatic test_miss();
    do_clear();
    repeat (5) window(1'b1);
    beat_only();
    checks++;
    if (combo_count !== 14'd5) $display("FAIL window_open: combo=%0d want 5", combo_count); else passes++;
    beat_tick = 1'b1;
    tick();
    tick();
    beat_tick = 1'b0;
    m_combo = 0;
    push_exp();
    tick();
    pop_cmp("miss", 1'b1);
    checks++;
    if (combo_en !== 1'b1) $display("FAIL miss_en_lag: combo_en=%0b want 1", combo_en); else passes++;
    tick();
    checks++;
    if (combo_en !== 1'b0) $display("FAIL miss_en_drop: combo_en=%0b want 0", combo_en); else passes++;
    tick();
  endtask

  task automatic test_bonus_run();
    do_clear();
    repeat (12) window(1'b1);
    checks++;
    if (score !== 14'd18 || combo_count !== 14'd12)
      $display("FAIL bonus_run: score=%0d combo=%0d want 18/12", score, combo_count);
    else passes++;
  endtask

  task automatic test_simul_pause_clear();
    beat_only();
    correct_hit = 1'b1;
    incorrect_hit = 1'b1;
    m_combo = 0;
    push_exp();
    tick();
    pop_cmp("simultaneous", 1'b1);
    correct_hit = 1'b0;
    incorrect_hit = 1'b0;
    tick();
    window(1'b1);
    beat_only();
    pause = 1'b1;
    repeat (3) beat_only();
    correct_hit = 1'b1;
    tick();
    tick();
    checks++;
    if (score !== 14'd19 || combo_count !== 14'd1)
      $display("FAIL paused: score=%0d combo=%0d want 19/1", score, combo_count);
    else passes++;
    pause = 1'b0;
    tick();
    tick();
    checks++;
    if (score !== 14'd19 || combo_count !== 14'd1)
      $display("FAIL pause_release: score=%0d combo=%0d want 19/1", score, combo_count);
    else passes++;
    correct_hit = 1'b0;
    tick();
    do_clear();
    checks++;
`ifdef SCORE_KEEPER_BEST_COMBO_EN
    if (best_combo !== 14'd12) $display("FAIL best_after_clear: got %0d want 12", best_combo); else passes++;
`else
    if (best_combo !== 14'd0) $display("FAIL best_tied_off: got %0d want 0", best_combo); else passes++;
`endif
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 10000; i++)
      window((i >= 3330 && i <= 3345) || i >= 9990);
    checks++;
    if (score !== 14'd9999 || combo_count !== 14'd9999)
      $display("FAIL saturation: score=%0d combo=%0d want 9999/9999", score, combo_count);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_three_windows();
    test_anti_mash();
    test_miss();
    test_bonus_run();
    test_simul_pause_clear();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
